// File: rtl/inst_pkg.sv
// Shared MIPS instruction-format codes, field bit positions and loader FSM
// state encodings.
package inst_pkg;

    localparam logic [1:0] FMT_R   = 2'b00;
    localparam logic [1:0] FMT_I   = 2'b01;
    localparam logic [1:0] FMT_J   = 2'b10;
    localparam logic [1:0] FMT_BAD = 2'b11;

    localparam int OP_HI    = 31;
    localparam int OP_LO    = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int SHAMT_HI = 10;
    localparam int SHAMT_LO = 6;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;
    localparam int TGT_HI   = 25;
    localparam int TGT_LO   = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_RD    = 3'd3,
        ST_CHK   = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
    } fields_t;

endpackage

// File: rtl/inst_encoder.sv
// Combinational MIPS encoder: decoded fields plus format code -> 32-bit word,
// with an illegal flag for the reserved format.
module inst_encoder
    import inst_pkg::*;
(
    input  logic [1:0]  fmt,
    input  fields_t     f,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (fmt)
            FMT_R: begin
                word[OP_HI:OP_LO]       = f.op;
                word[RS_HI:RS_LO]       = f.rs;
                word[RT_HI:RT_LO]       = f.rt;
                word[RD_HI:RD_LO]       = f.rd;
                word[SHAMT_HI:SHAMT_LO] = f.shamt;
                word[FUNCT_HI:FUNCT_LO] = f.funct;
            end
            FMT_I: begin
                word[OP_HI:OP_LO]   = f.op;
                word[RS_HI:RS_LO]   = f.rs;
                word[RT_HI:RT_LO]   = f.rt;
                word[IMM_HI:IMM_LO] = f.imm;
            end
            FMT_J: begin
                word[OP_HI:OP_LO]   = f.op;
                word[TGT_HI:TGT_LO] = f.target;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/inst_mem_loader.sv
// Sequential instruction-RAM writer fed by decoded field tuples.
// Define INST_MEM_LOADER_READBACK_EN to verify each word by reading it back.
module inst_mem_loader
    import inst_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [1:0]        fmt,
    input  logic [5:0]        op_code,
    input  logic [4:0]        rs_addr,
    input  logic [4:0]        rt_addr,
    input  logic [4:0]        rd_addr,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    fields_t     fields;
    logic [31:0] enc_word;
    logic        enc_illegal;

    assign fields = '{op: op_code, rs: rs_addr, rt: rt_addr, rd: rd_addr,
                      shamt: shamt, funct: funct, imm: imm, target: target};

    inst_encoder u_enc (
        .fmt     (fmt),
        .f       (fields),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    state_e            state_q, state_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              full_q, full_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;
    logic              in_ready_q, in_ready_d;
    logic              last_q, last_d;

    logic              adv;
    logic              fin;
    logic [ADDR_W:0]   fin_cnt;
    logic [ADDR_W:0]   cnt_inc;

`ifndef INST_MEM_LOADER_READBACK_EN
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;
`endif

    assign cnt_inc = count_q + (ADDR_W+1)'(1);

    always_comb begin
        state_d     = state_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        busy_d      = busy_q;
        done_d      = done_q;
        full_d      = full_q;
        count_d     = count_q;
        err_d       = err_q;
        last_d      = last_q;
        adv         = 1'b0;
        fin         = 1'b0;
        fin_cnt     = count_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_LOAD;
                    mem_addr_d = '0;
                    count_d    = '0;
                    err_d      = 1'b0;
                    full_d     = 1'b0;
                    done_d     = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            ST_LOAD: begin
                if (in_valid && in_ready_q) begin
                    last_d = in_last;
                    if (enc_illegal) begin
                        // Illegal tuple is swallowed without a write but may still close the session.
                        err_d = 1'b1;
                        fin   = in_last;
                    end else begin
                        mem_we_d    = 1'b1;
                        mem_wdata_d = enc_word;
                        state_d     = ST_WRITE;
                    end
                end
            end
`ifdef INST_MEM_LOADER_READBACK_EN
            ST_WRITE: state_d = ST_RD;
            ST_RD:    state_d = ST_CHK;
            ST_CHK: begin
                if (mem_rdata != mem_wdata_q)
                    err_d = 1'b1;
                adv = 1'b1;
            end
`else
            ST_WRITE: adv = 1'b1;
`endif
            default: state_d = ST_IDLE;
        endcase

        // Pointer stops at the last word so it never wraps; count tops out at DEPTH.
        if (adv) begin
            count_d = cnt_inc;
            if (cnt_inc < DEPTH_C)
                mem_addr_d = mem_addr_q + ADDR_W'(1);
            if (last_q || cnt_inc == DEPTH_C) begin
                fin     = 1'b1;
                fin_cnt = cnt_inc;
            end else begin
                state_d = ST_LOAD;
            end
        end

        if (fin) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            full_d  = (fin_cnt == DEPTH_C);
        end

        in_ready_d = (state_d == ST_LOAD) && !full_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            full_q      <= 1'b0;
            count_q     <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            full_q      <= full_d;
            count_q     <= count_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            last_q      <= last_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign full      = full_q;
    assign count     = count_q;
    assign err       = err_q;
    assign in_ready  = in_ready_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader: driver pushes expected RAM writes,
// a monitor pops them on every mem_we; session status checked at done.
module tb_inst_mem_loader;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_ready, in_last;
    logic [1:0]  fmt;
    logic [5:0]  op_code, funct;
    logic [4:0]  rs_addr, rt_addr, rd_addr, shamt;
    logic [15:0] imm;
    logic [25:0] target;
    logic        mem_we, busy, done, full, err;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [6:0]  count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    int model_ptr;
    bit model_err;
    bit corrupt_en = 1'b0;

    logic [31:0] ram [64];

    always #5 clk = ~clk;

    inst_mem_loader dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .fmt(fmt), .op_code(op_code), .rs_addr(rs_addr),
        .rt_addr(rt_addr), .rd_addr(rd_addr), .shamt(shamt), .funct(funct),
        .imm(imm), .target(target), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .done(done),
        .full(full), .count(count), .err(err)
    );

    // Synchronous RAM; optional corruption of the read path at word 2
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= (corrupt_en && mem_addr == 6'd2) ? (ram[mem_addr] ^ 32'h1) : ram[mem_addr];
    end

    // Monitor: every write must match the oldest expected write
    always @(negedge clk) begin
        if (!rst && mem_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got addr=%0d data=%h, expected no write", mem_addr, mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (mem_addr !== mon_e.addr || mem_wdata !== mon_e.data) begin
                    errors++;
                    $display("FAIL write got addr=%0d data=%h, expected addr=%0d data=%h",
                             mem_addr, mem_wdata, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_enc(input logic [1:0] f, input logic [5:0] op,
                                             input logic [4:0] rs, input logic [4:0] rt,
                                             input logic [4:0] rd, input logic [4:0] sh,
                                             input logic [5:0] fn, input logic [15:0] im,
                                             input logic [25:0] tg);
        if (f == 2'b00) return {op, rs, rt, rd, sh, fn};
        if (f == 2'b01) return {op, rs, rt, im};
        return {op, tg};
    endfunction

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_ptr = 0;
        model_err = 1'b0;
    endtask

    // Offer a tuple until accepted or the bound expires; model updated on acceptance
    task automatic send_try(input logic [1:0] f, input logic [5:0] op, input logic [4:0] rs,
                            input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                            input logic [5:0] fn, input logic [15:0] im, input logic [25:0] tg,
                            input logic last, input int bound, output bit acc);
        int n = 0;
        @(negedge clk);
        fmt = f; op_code = op; rs_addr = rs; rt_addr = rt; rd_addr = rd;
        shamt = sh; funct = fn; imm = im; target = tg; in_last = last; in_valid = 1'b1;
        while (!in_ready && n < bound) begin
            @(negedge clk);
            n++;
        end
        acc = in_ready;
        if (acc) begin
            if (f == 2'b11) model_err = 1'b1;
            else begin
                exp_q.push_back('{addr: 6'(model_ptr), data: ref_enc(f, op, rs, rt, rd, sh, fn, im, tg)});
`ifdef INST_MEM_LOADER_READBACK_EN
                if (corrupt_en && model_ptr == 2) model_err = 1'b1;
`endif
                model_ptr++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send(input logic [1:0] f, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                        input logic [5:0] fn, input logic [15:0] im, input logic [25:0] tg,
                        input logic last);
        bit acc;
        send_try(f, op, rs, rt, rd, sh, fn, im, tg, last, 50, acc);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got in_ready=0 expected 1");
        end
    endtask

    task automatic send_rand(input logic [1:0] f, input logic last);
        send(f, 6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
             6'($urandom), 16'($urandom), 26'($urandom), last);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_count"}, 32'(count), 32'(model_ptr));
        chk({tag, "_full"}, 32'(full), 32'(model_ptr == 64));
        chk({tag, "_err"}, 32'(err), 32'(model_err));
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bit acc;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; fmt = 2'b00;
        op_code = '0; rs_addr = '0; rt_addr = '0; rd_addr = '0; shamt = '0;
        funct = '0; imm = '0; target = '0;
        repeat (3) @(negedge clk);
        chk("rst_outputs", {mem_we, busy, done, full, err, in_ready, count, mem_addr},
            32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        rst = 1'b0;

        // add, addi, j
        do_start();
        chk("start_busy", 32'(busy), 32'd1);
        send(2'b00, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1'b0);
        send(2'b01, 6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0005, 26'h0, 1'b0);
        send(2'b10, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h10, 1'b1);
        wait_done("dir3");
        chk("ram0_add", ram[0], 32'h00221820);
        chk("ram1_addi", ram[1], 32'h20220005);
        chk("ram2_j", ram[2], 32'h08000010);

        // illegal format between two words
        do_start();
        send_rand(2'b00, 1'b0);
        send_rand(2'b11, 1'b0);
        send_rand(2'b01, 1'b1);
        wait_done("illegal");
        do_start();
        chk("err_cleared", 32'(err), 32'd0);
        chk("done_cleared", 32'(done), 32'd0);
        send_rand(2'b11, 1'b1);
        wait_done("illegal_last");

        // fill all 64 words, then a 65th must be refused
        do_start();
        for (int i = 0; i < 64; i++) send_rand(2'($urandom_range(0, 2)), 1'b0);
        wait_done("full");
        send_try(2'b00, 6'h1, 5'd1, 5'd1, 5'd1, 5'd1, 6'h1, 16'h1, 26'h1, 1'b0, 10, acc);
        chk("no_accept_65", 32'(acc), 32'd0);
        chk("full_count_hold", 32'(count), 32'd64);

        // random sessions with gaps and occasional illegal tuples
        for (int s = 0; s < 5; s++) begin
            int len;
            len = $urandom_range(1, 10);
            do_start();
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send_rand(($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2)), i == len - 1);
            end
            wait_done("rand");
        end

        // reset during WRITE
        do_start();
        send_rand(2'b00, 1'b0);
        chk("in_write_we", 32'(mem_we), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_we", 32'(mem_we), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_count", 32'(count), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        do_start();
        send_rand(2'b01, 1'b0);
        send_rand(2'b10, 1'b1);
        wait_done("after_rst");

        // read path corrupts word 2; error only reported with readback enabled
        corrupt_en = 1'b1;
        do_start();
        for (int i = 0; i < 5; i++) send_rand(2'($urandom_range(0, 2)), i == 4);
        wait_done("readback");
        corrupt_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
